// File: rtl/fsm_dsr_multi.sv
// Purpose : framed byte-stream recogniser (START/READ/PROC/DONE) with an N-stage mode-rotated op chain,
//           WAIT timeout, ERROR recovery and synchronous abort.
// Latency : 1 cycle; a beat consumed at edge n shows on data_out/out_valid after edge n.
// Backpr. : none toward the sender; in_valid=0 stalls START/READ/PROC/ERROR in place, and WAIT keeps counting.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   start, mode[1:0], abort   frame request (honoured in IDLE only), op-rotation seed, synchronous abort
//   in_valid, data_in         stream beat qualifier and data
//   data_out, out_valid, done registered result, result qualifier, one-cycle frame-complete pulse
//   busy, error               state != IDLE, state == ERROR (decoded from the state register)
//   frames_ok, frames_err     saturating frame counters, present only when FSM_DSR_MULTI_STATS_EN is defined
//
// Build option: define FSM_DSR_MULTI_STATS_EN to add the frames_ok/frames_err counters and ports.
// Parameter legality: DATA_W >= 8, PROC_STAGES 1..8, WAIT_TIMEOUT 1..255.

module fsm_dsr_multi #(
    parameter int          DATA_W       = 8,
    parameter int          PROC_STAGES  = 3,
    parameter int          WAIT_TIMEOUT = 15,
    parameter int unsigned ERR_CODE     = 'hEE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              done,
    output logic              busy,
    output logic              error
`ifdef FSM_DSR_MULTI_STATS_EN
    ,
    output logic [15:0]       frames_ok,
    output logic [15:0]       frames_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_READ,
        S_PROC,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    // ERR_CODE is zero-extended or truncated to the data width.
    localparam logic [DATA_W-1:0] ERR_VAL    = DATA_W'(ERR_CODE);
    localparam logic [2:0]        LAST_STAGE = 3'(PROC_STAGES - 1);
    localparam logic [7:0]        WAIT_LAST  = 8'(WAIT_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [2:0]        stage_q, stage_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;

    // Per-stage transform, all modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] apply_op(input logic [1:0] sel, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        case (sel)
            2'd0:    r = d + DATA_W'(1);
            2'd1:    r = {d[DATA_W-2:0], 1'b0};
            2'd2:    r = ~d;
            default: r = {d[DATA_W-2:0], d[DATA_W-1]};
        endcase
        return r;
    endfunction

    // Op index rotates with the stage; a 2-bit add gives the modulo-4 wrap for free.
    logic [1:0] op_sel;
    assign op_sel = mode_q + stage_q[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stage_q     <= '0;
            wait_cnt_q  <= '0;
            mode_q      <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            wait_cnt_q  <= wait_cnt_d;
            mode_q      <= mode_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        wait_cnt_d  = wait_cnt_q;
        mode_d      = mode_q;
        data_out_d  = '0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;

        if (abort) begin
            // Abort beats everything but reset: drop the frame, emit nothing, ignore start.
            state_d    = S_IDLE;
            stage_d    = '0;
            wait_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_START;
                        mode_d  = mode;
                    end
                end
                S_START: begin
                    if (in_valid) begin
                        state_d = data_in[0] ? S_READ : S_ERROR;
                    end
                end
                S_READ: begin
                    if (in_valid) begin
                        out_valid_d = 1'b1;
                        data_out_d  = data_in;
                        if (data_in[3:1] == 3'b101) begin
                            state_d = S_PROC;
                            stage_d = '0;
                        end else begin
                            state_d    = S_WAIT;
                            wait_cnt_d = '0;
                        end
                    end
                end
                S_PROC: begin
                    if (in_valid) begin
                        out_valid_d = 1'b1;
                        data_out_d  = apply_op(op_sel, data_in);
                        // The first stage never checks the continuation MSB.
                        if (stage_q == 3'd0 || data_in[DATA_W-1]) begin
                            if (stage_q == LAST_STAGE) begin
                                state_d = S_DONE;
                            end else begin
                                stage_d = stage_q + 3'd1;
                            end
                        end else begin
                            state_d    = S_WAIT;
                            wait_cnt_d = '0;
                        end
                    end
                end
                S_WAIT: begin
                    // Idle cycles count toward the timeout as well as non-matching beats.
                    if (in_valid && data_in[4]) begin
                        state_d = S_READ;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_d = S_ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    out_valid_d = in_valid;
                    data_out_d  = in_valid ? data_in : '0;
                end
                S_ERROR: begin
                    if (in_valid) begin
                        out_valid_d = 1'b1;
                        data_out_d  = ERR_VAL;
                        if (data_in[2:0] == 3'b111) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign error     = (state_q == S_ERROR);

`ifdef FSM_DSR_MULTI_STATS_EN
    logic [15:0] frames_ok_q, frames_err_q;
    logic        ok_inc, err_inc;

    // DONE and ERROR are entered from a different state, so a state change into them marks one event.
    // Abort forces IDLE and therefore never counts.
    assign ok_inc  = (state_d == S_DONE)  && (state_q != S_DONE);
    assign err_inc = (state_d == S_ERROR) && (state_q != S_ERROR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_ok_q  <= '0;
            frames_err_q <= '0;
        end else begin
            if (ok_inc && frames_ok_q != 16'hFFFF) begin
                frames_ok_q <= frames_ok_q + 16'd1;
            end
            if (err_inc && frames_err_q != 16'hFFFF) begin
                frames_err_q <= frames_err_q + 16'd1;
            end
        end
    end

    assign frames_ok  = frames_ok_q;
    assign frames_err = frames_err_q;
`endif

endmodule

// File: tb/tb_fsm_dsr_multi.sv
// Bench for fsm_dsr_multi: an 8-bit instance checked every cycle against a frame-level model,
// plus a 16-bit PROC_STAGES=4 instance checked with hand-computed literals.
module tb_fsm_dsr_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start, abort, in_valid;
    logic [1:0] mode;
    logic [7:0] data_in, data_out;
    logic       out_valid, done, busy, error;

    logic        w_start, w_abort, w_in_valid;
    logic [1:0]  w_mode;
    logic [15:0] w_data_in, w_data_out;
    logic        w_out_valid, w_done, w_busy, w_error;

`ifdef FSM_DSR_MULTI_STATS_EN
    logic [15:0] frames_ok, frames_err, w_frames_ok, w_frames_err;
`endif

    fsm_dsr_multi u_dut8 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .in_valid(in_valid), .data_in(data_in), .data_out(data_out),
        .out_valid(out_valid), .done(done), .busy(busy), .error(error)
`ifdef FSM_DSR_MULTI_STATS_EN
        , .frames_ok(frames_ok), .frames_err(frames_err)
`endif
    );

    fsm_dsr_multi #(.DATA_W(16), .PROC_STAGES(4)) u_dut16 (
        .clk(clk), .rst(rst), .start(w_start), .mode(w_mode), .abort(w_abort),
        .in_valid(w_in_valid), .data_in(w_data_in), .data_out(w_data_out),
        .out_valid(w_out_valid), .done(w_done), .busy(w_busy), .error(w_error)
`ifdef FSM_DSR_MULTI_STATS_EN
        , .frames_ok(w_frames_ok), .frames_err(w_frames_err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model of the 8-bit instance ----------------
    // Phases: 0 idle, 1 awaiting start beat, 2 awaiting read beat, 3 in transform chain,
    //         4 waiting for resync, 5 frame complete, 6 error recovery.
    localparam int M_STAGES  = 3;
    localparam int M_TIMEOUT = 15;
    localparam int M_ERR     = 'hEE;

    int         m_phase, m_stage, m_wait, m_mode, m_ok, m_err;
    logic [7:0] m_dat;
    logic       m_vld, m_done;

    function automatic int op8(input int sel, input int d);
        case (sel)
            0:       return (d + 1) % 256;
            1:       return (d * 2) % 256;
            2:       return 255 - d;
            default: return (d * 2) % 256 + d / 128;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_stage <= 0; m_wait <= 0; m_mode <= 0;
            m_ok <= 0; m_err <= 0; m_dat <= 8'h00; m_vld <= 1'b0; m_done <= 1'b0;
        end else begin
            m_dat  <= 8'h00;
            m_vld  <= 1'b0;
            m_done <= 1'b0;
            if (abort) begin
                m_phase <= 0; m_stage <= 0; m_wait <= 0;
            end else begin
                case (m_phase)
                    0: if (start) begin m_phase <= 1; m_mode <= int'(mode); end
                    1: if (in_valid) begin
                        if (data_in[0]) m_phase <= 2;
                        else begin m_phase <= 6; m_err <= m_err + 1; end
                    end
                    2: if (in_valid) begin
                        m_vld <= 1'b1; m_dat <= data_in;
                        if ((int'(data_in) / 2) % 8 == 5) begin m_phase <= 3; m_stage <= 0; end
                        else begin m_phase <= 4; m_wait <= 0; end
                    end
                    3: if (in_valid) begin
                        m_vld <= 1'b1;
                        m_dat <= 8'(op8((m_mode + m_stage) % 4, int'(data_in)));
                        if (m_stage == 0 || int'(data_in) >= 128) begin
                            if (m_stage == M_STAGES - 1) begin m_phase <= 5; m_ok <= m_ok + 1; end
                            else m_stage <= m_stage + 1;
                        end else begin
                            m_phase <= 4; m_wait <= 0;
                        end
                    end
                    4: if (in_valid && (int'(data_in) / 16) % 2 == 1) m_phase <= 2;
                       else if (m_wait == M_TIMEOUT - 1) begin m_phase <= 6; m_err <= m_err + 1; end
                       else m_wait <= m_wait + 1;
                    5: begin
                        m_phase <= 0; m_done <= 1'b1;
                        if (in_valid) begin m_vld <= 1'b1; m_dat <= data_in; end
                    end
                    default: if (in_valid) begin
                        m_vld <= 1'b1; m_dat <= 8'(M_ERR);
                        if (int'(data_in) % 8 == 7) m_phase <= 0;
                    end
                endcase
            end
        end
    end

    // Compare process: every falling edge, all 8-bit outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_data_out",  32'(data_out),  32'(m_dat));
            check("cyc_out_valid", 32'(out_valid), 32'(m_vld));
            check("cyc_done",      32'(done),      32'(m_done));
            check("cyc_busy",      32'(busy),      32'(m_phase != 0));
            check("cyc_error",     32'(error),     32'(m_phase == 6));
`ifdef FSM_DSR_MULTI_STATS_EN
            check("cyc_frames_ok",  32'(frames_ok),  32'(m_ok));
            check("cyc_frames_err", 32'(frames_err), 32'(m_err));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic s, input logic [1:0] m, input logic a, input logic v, input logic [7:0] d);
        @(negedge clk);
        start = s; mode = m; abort = a; in_valid = v; data_in = d;
    endtask

    task automatic beat(input logic [7:0] d);
        cyc(1'b0, 2'd0, 1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic cyc16(input logic s, input logic [1:0] m, input logic v, input logic [15:0] d);
        @(negedge clk);
        w_start = s; w_mode = m; w_abort = 1'b0; w_in_valid = v; w_data_in = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0; mode = 2'd0; abort = 1'b0; in_valid = 1'b0; data_in = 8'h00;
        w_start = 1'b0; w_mode = 2'd0; w_abort = 1'b0; w_in_valid = 1'b0; w_data_in = 16'h0000;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_outputs", 32'({data_out, out_valid, done, busy, error}), 32'(0));
        check("rst_outputs16", 32'({w_data_out, w_out_valid, w_done, w_busy, w_error}), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // 1: mode 0 frame, ops +1, shl, xor
        cyc(1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
        beat(8'h01);
        beat(8'h0B); tick; check("t1_read", 32'({out_valid, data_out}), 32'({1'b1, 8'h0B}));
        beat(8'h10); tick; check("t1_op_inc", 32'({out_valid, data_out}), 32'({1'b1, 8'h11}));
        beat(8'h80); tick; check("t1_op_shl", 32'({out_valid, data_out}), 32'({1'b1, 8'h00}));
        beat(8'h80); tick; check("t1_op_xor", 32'({out_valid, data_out}), 32'({1'b1, 8'h7F}));
        idle(1);     tick; check("t1_done", 32'({done, busy, out_valid}), 32'(3'b100));
        idle(2);

        // 2: bad start beat -> ERROR, recovery on xxxxx111
        cyc(1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
        idle(2);
        beat(8'h00); tick; check("t2_error_on", 32'({error, out_valid}), 32'(2'b10));
        beat(8'h00); tick; check("t2_err_code", 32'({out_valid, data_out}), 32'({1'b1, 8'hEE}));
        beat(8'h07); tick; check("t2_exit", 32'({error, busy, out_valid, data_out}), 32'({2'b00, 1'b1, 8'hEE}));
        idle(1);

        // 3: READ miss -> WAIT, 15 idle cycles -> ERROR
        cyc(1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
        beat(8'h01);
        beat(8'h00);
        idle(14); tick; check("t3_wait_14", 32'({busy, error}), 32'(2'b10));
        idle(1);  tick; check("t3_timeout", 32'({busy, error}), 32'(2'b11));
`ifdef FSM_DSR_MULTI_STATS_EN
        check("t3_frames_err", 32'(frames_err), 32'(2));
        check("t3_frames_ok",  32'(frames_ok),  32'(1));
`endif
        beat(8'h0F);
        idle(1);

        // WAIT resync, PROC MSB miss back to WAIT, then abort in stage 1 with start high
        cyc(1'b1, 2'd1, 1'b0, 1'b0, 8'h00);
        beat(8'h01);
        beat(8'h00);
        idle(3);
        beat(8'h10);
        beat(8'h0A);
        beat(8'h81); tick; check("t5_mode1_shl", 32'({out_valid, data_out}), 32'({1'b1, 8'h02}));
        beat(8'h05); tick; check("t5_msb_miss", 32'({out_valid, data_out, busy}), 32'({1'b1, 8'hFA, 1'b1}));
        idle(2);
        beat(8'h13);
        beat(8'h0B);
        beat(8'h40);
        cyc(1'b1, 2'd2, 1'b1, 1'b1, 8'h80); tick;
        check("t5_abort", 32'({busy, out_valid, data_out}), 32'(0));
        idle(1); tick; check("t5_start_dropped", 32'(busy), 32'(0));

        // mode 2 frame, DONE beat with in_valid passes data through
        cyc(1'b1, 2'd2, 1'b0, 1'b0, 8'h00);
        beat(8'h01);
        beat(8'h0B);
        beat(8'h0F); tick; check("t7_op_xor", 32'(data_out), 32'(8'hF0));
        beat(8'h81); tick; check("t7_op_rot", 32'(data_out), 32'(8'h03));
        beat(8'hFF); tick; check("t7_op_wrap", 32'({out_valid, data_out}), 32'({1'b1, 8'h00}));
        beat(8'h5A); tick; check("t7_done_beat", 32'({done, out_valid, data_out}), 32'({2'b11, 8'h5A}));
        idle(1);

        // 6: async reset mid-WAIT (wait_cnt=9), then a full-length timeout
        cyc(1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
        beat(8'h01);
        beat(8'h00);
        idle(9);
        @(negedge clk); #2 rst = 1'b1;
        #1 check("t6_async_rst", 32'({busy, error, out_valid, done, data_out}), 32'(0));
        @(negedge clk); rst = 1'b0;
        cyc(1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
        beat(8'h01);
        beat(8'h00);
        idle(14); tick; check("t6_wait_14", 32'(error), 32'(0));
        idle(1);  tick; check("t6_timeout", 32'(error), 32'(1));
`ifdef FSM_DSR_MULTI_STATS_EN
        check("t6_frames_err", 32'(frames_err), 32'(1));
`endif
        beat(8'h07);
        idle(1);

        // 4: 16-bit, 4 stages, mode 3: rot, +1, shl, xor on 8001
        cyc16(1'b1, 2'd3, 1'b0, 16'h0000);
        cyc16(1'b0, 2'd0, 1'b1, 16'h0001);
        cyc16(1'b0, 2'd0, 1'b1, 16'h000B); tick; check("t4_read",  32'({w_out_valid, w_data_out}), 32'({1'b1, 16'h000B}));
        cyc16(1'b0, 2'd0, 1'b1, 16'h8001); tick; check("t4_rot",   32'({w_out_valid, w_data_out}), 32'({1'b1, 16'h0003}));
        cyc16(1'b0, 2'd0, 1'b1, 16'h8001); tick; check("t4_inc",   32'({w_out_valid, w_data_out}), 32'({1'b1, 16'h8002}));
        cyc16(1'b0, 2'd0, 1'b1, 16'h8001); tick; check("t4_shl",   32'({w_out_valid, w_data_out}), 32'({1'b1, 16'h0002}));
        cyc16(1'b0, 2'd0, 1'b1, 16'h8001); tick; check("t4_xor",   32'({w_out_valid, w_data_out, w_done}), 32'({1'b1, 16'h7FFE, 1'b0}));
        cyc16(1'b0, 2'd0, 1'b0, 16'h0000); tick; check("t4_done",  32'({w_done, w_busy, w_out_valid}), 32'(3'b100));
        cyc16(1'b1, 2'd0, 1'b0, 16'h0000);
        cyc16(1'b0, 2'd0, 1'b1, 16'h0000); tick; check("t4_err_on", 32'(w_error), 32'(1));
        cyc16(1'b0, 2'd0, 1'b1, 16'h0000); tick; check("t4_err_code", 32'({w_out_valid, w_data_out}), 32'({1'b1, 16'h00EE}));
        cyc16(1'b0, 2'd0, 1'b1, 16'h0007); tick; check("t4_err_exit", 32'({w_error, w_busy}), 32'(0));
`ifdef FSM_DSR_MULTI_STATS_EN
        check("t4_frames", 32'({w_frames_ok, w_frames_err}), 32'({16'd1, 16'd1}));
`endif
        cyc16(1'b0, 2'd0, 1'b0, 16'h0000);
        idle(2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
